// File: rtl/conv_seq_engine.sv
// Sequential 1-D convolution engine: loads N x/h pairs, then computes the 2N-1 outputs on one MAC.
// Optional clamp of each result to DW bits is enabled by defining CONV_SAT_EN.
module conv_seq_engine #(
    parameter int N  = 8,
    parameter int DW = 4,
    parameter int OW = 2*DW + $clog2(N)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW-1:0]              x_in,
    input  logic [DW-1:0]              h_in,
    output logic                       y_valid,
    input  logic                       y_ready,
    output logic [OW-1:0]              y_out,
    output logic [$clog2(2*N-1)-1:0]   y_idx,
    output logic                       y_sat,
    output logic                       busy,
    output logic                       done
);
    localparam int KW = $clog2(N);
    localparam int YW = $clog2(2*N-1);
    localparam logic [KW-1:0] K_LAST = KW'(N-1);
    localparam logic [YW-1:0] N_LAST = YW'(2*N-2);
    localparam logic [YW:0]   N_EXT  = (YW+1)'(N);

    typedef enum logic [1:0] {IDLE, LOAD, MAC, OUT} state_t;

    state_t                 state_q, state_d;
    logic [N-1:0][DW-1:0]   xbuf_q, xbuf_d, hbuf_q, hbuf_d;
    logic [KW-1:0]          i_q, i_d, k_q, k_d;
    logic [YW-1:0]          n_q, n_d, y_idx_q, y_idx_d;
    logic [OW-1:0]          acc_q, acc_d, y_out_q, y_out_d;
    logic                   done_q, done_d;
    logic [YW:0]            diff;
    logic [2*DW-1:0]        prod;
    logic [OW-1:0]          sum;
`ifdef CONV_SAT_EN
    logic                   y_sat_q, y_sat_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // done_q high marks the first IDLE cycle; start is not honoured until it clears
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && !done_q)              state_d = LOAD;
            LOAD: if (in_valid && i_q == K_LAST)     state_d = MAC;
            MAC:  if (k_q == K_LAST)                 state_d = OUT;
            OUT:  if (y_ready)                       state_d = (n_q == N_LAST) ? IDLE : MAC;
            default:                                 state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == LOAD);
        y_valid  = (state_q == OUT);
        busy     = (state_q != IDLE);
        done     = done_q;
        y_out    = y_out_q;
        y_idx    = y_idx_q;
`ifdef CONV_SAT_EN
        y_sat    = y_valid & y_sat_q;
`else
        y_sat    = 1'b0;
`endif
    end

    // Term is zero when h index n-k falls outside 0..N-1
    always_comb begin
        diff = {1'b0, n_q} - (YW+1)'(k_q);
        prod = '0;
        if (!diff[YW] && diff < N_EXT)
            prod = xbuf_q[k_q] * hbuf_q[diff[KW-1:0]];
        sum = acc_q + OW'(prod);
    end

    always_comb begin
        xbuf_d  = xbuf_q;
        hbuf_d  = hbuf_q;
        i_d     = i_q;
        k_d     = k_q;
        n_d     = n_q;
        acc_d   = acc_q;
        y_out_d = y_out_q;
        y_idx_d = y_idx_q;
        done_d  = 1'b0;
`ifdef CONV_SAT_EN
        y_sat_d = y_sat_q;
`endif
        case (state_q)
            IDLE: i_d = '0;
            LOAD: if (in_valid) begin
                xbuf_d[i_q] = x_in;
                hbuf_d[i_q] = h_in;
                i_d         = i_q + 1'b1;
                if (i_q == K_LAST) begin
                    n_d   = '0;
                    k_d   = '0;
                    acc_d = '0;
                end
            end
            MAC: begin
                acc_d = sum;
                k_d   = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    y_idx_d = n_q;
`ifdef CONV_SAT_EN
                    y_sat_d = (sum > OW'(2**DW-1));
                    y_out_d = y_sat_d ? OW'(2**DW-1) : sum;
`else
                    y_out_d = sum;
`endif
                end
            end
            OUT: if (y_ready) begin
                acc_d = '0;
                k_d   = '0;
                if (n_q == N_LAST) done_d = 1'b1;
                else               n_d    = n_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xbuf_q  <= '0;
            hbuf_q  <= '0;
            i_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            y_out_q <= '0;
            y_idx_q <= '0;
            done_q  <= 1'b0;
`ifdef CONV_SAT_EN
            y_sat_q <= 1'b0;
`endif
        end else begin
            xbuf_q  <= xbuf_d;
            hbuf_q  <= hbuf_d;
            i_q     <= i_d;
            k_q     <= k_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            y_out_q <= y_out_d;
            y_idx_q <= y_idx_d;
            done_q  <= done_d;
`ifdef CONV_SAT_EN
            y_sat_q <= y_sat_d;
`endif
        end
    end

endmodule

// File: tb/tb_conv_seq_engine.sv
// Self-checking bench for conv_seq_engine: directed and random jobs against a direct-sum convolution model.
module tb_conv_seq_engine;
    localparam int N  = 8;
    localparam int DW = 4;
    localparam int OW = 2*DW + $clog2(N);
    localparam int YW = $clog2(2*N-1);

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, y_ready = 1'b0;
    logic [DW-1:0] x_in = '0, h_in = '0;
    logic          in_ready, y_valid, y_sat, busy, done;
    logic [OW-1:0] y_out;
    logic [YW-1:0] y_idx;

    int checks = 0, passes = 0;
    int tx[N], th[N];

    always #5 clk = ~clk;

    conv_seq_engine #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .h_in(h_in), .y_valid(y_valid), .y_ready(y_ready), .y_out(y_out),
        .y_idx(y_idx), .y_sat(y_sat), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int raw_y(input int n);
        int s = 0;
        for (int k = 0; k < N; k++)
            if (n - k >= 0 && n - k < N) s += tx[k] * th[n-k];
        return s;
    endfunction

    function automatic int ref_y(input int n);
`ifdef CONV_SAT_EN
        return (raw_y(n) > 2**DW-1) ? 2**DW-1 : raw_y(n);
`else
        return raw_y(n);
`endif
    endfunction

    function automatic int ref_sat(input int n);
`ifdef CONV_SAT_EN
        return (raw_y(n) > 2**DW-1) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_y_valid"}, y_valid, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_y_out"}, y_out, 0);
        chk({tag, "_y_idx"}, y_idx, 0);
        chk({tag, "_y_sat"}, y_sat, 0);
    endtask

    // One job: optional load stalls, random y_ready, backpressure at bp_idx,
    // a stray start during MAC of result start_at, and a reset abort during MAC of abort_at.
    task automatic run_job(input bit stall_in, input bit rnd_rdy, input int bp_idx,
                           input int start_at, input int abort_at);
        int cnt, lat, guard;
        bit hs;
        logic [OW-1:0] hold_y;
        logic [YW-1:0] hold_i;
        @(negedge clk);
        in_valid = 1'b0;
        y_ready  = rnd_rdy ? 1'b0 : 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_to_ready", in_ready, 1);
        chk("busy_load", busy, 1);
        cnt = 0; guard = 0;
        while (cnt < N && guard < 200) begin
            in_valid = stall_in ? 1'($urandom % 2) : 1'b1;
            x_in = DW'(tx[cnt]);
            h_in = DW'(th[cnt]);
            hs = in_valid && in_ready;
            @(negedge clk);
            guard++;
            if (hs) cnt++;
        end
        chk("load_count", cnt, N);
        in_valid = 1'b0;
        lat = 1;
        for (int r = 0; r < 2*N-1; r++) begin
            guard = 0;
            while (!y_valid && guard < 100) begin
                if (r == abort_at && lat == 3) begin
                    rst_n = 1'b0;
                    #1;
                    chk_all_zero("abort");
                    repeat (3) begin
                        @(negedge clk);
                        chk("abort_no_done", done, 0);
                        chk("abort_idle", busy, 0);
                    end
                    rst_n = 1'b1;
                    in_valid = 1'b0;
                    start = 1'b0;
                    return;
                end
                in_valid = 1'($urandom % 2);
                x_in = DW'($urandom);
                h_in = DW'($urandom);
                start = (r == start_at && lat == 2);
                @(negedge clk);
                lat++; guard++;
            end
            in_valid = 1'b0;
            start = 1'b0;
            chk("latency", lat, N+1);
            chk("y_idx", y_idx, r);
            chk("y_out", y_out, ref_y(r));
            chk("y_sat", y_sat, ref_sat(r));
            hold_y = y_out;
            hold_i = y_idx;
            if (r == bp_idx) begin
                y_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_valid", y_valid, 1);
                    chk("bp_y_out", y_out, hold_y);
                    chk("bp_y_idx", y_idx, hold_i);
                end
            end
            y_ready = rnd_rdy ? 1'($urandom % 2) : 1'b1;
            while (!y_ready) begin
                @(negedge clk);
                chk("hold_y_out", y_out, hold_y);
                y_ready = 1'($urandom % 2);
            end
            @(negedge clk);
            y_ready = rnd_rdy ? 1'($urandom % 2) : 1'b1;
            if (r == 2*N-2) begin
                chk("done", done, 1);
                chk("busy_end", busy, 0);
            end else begin
                chk("valid_drop", y_valid, 0);
                chk("no_done", done, 0);
            end
            lat = 1;
        end
        @(negedge clk);
        chk("done_pulse", done, 0);
        y_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) begin tx[i] = 1; th[i] = 1; end
        run_job(1'b0, 1'b0, -1, -1, -1);

        for (int i = 0; i < N; i++) begin tx[i] = (i == 0) ? 1 : 0; th[i] = i + 2; end
        run_job(1'b0, 1'b0, -1, -1, -1);

        for (int i = 0; i < N; i++) begin tx[i] = 15; th[i] = 15; end
        run_job(1'b0, 1'b0, -1, -1, -1);

        for (int i = 0; i < N; i++) begin tx[i] = 1; th[i] = 1; end
        run_job(1'b0, 1'b0, 3, -1, -1);
        run_job(1'b1, 1'b0, -1, 2, -1);

        for (int i = 0; i < N; i++) begin tx[i] = $urandom_range(0, 15); th[i] = $urandom_range(0, 15); end
        run_job(1'b0, 1'b0, -1, -1, 5);
        tx = '{7, 3, 9, 2, 5, 1, 8, 4};
        th = '{6, 2, 7, 1, 9, 3, 5, 8};
        run_job(1'b0, 1'b0, -1, -1, -1);

        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < N; i++) begin tx[i] = $urandom_range(0, 15); th[i] = $urandom_range(0, 15); end
            run_job(1'b1, 1'b1, $urandom_range(0, 2*N-2), $urandom_range(0, 2*N-2), -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
